// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential double-dabble BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CORR  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    localparam int          DIGIT_W     = 4;
    localparam logic [7:0]  ASCII_ZERO  = 8'h30;
    localparam logic [3:0]  ADD3_THRESH = 4'd5;

    // Add-3 correction applied before each shift: digits of 5 or more would
    // exceed 9 after doubling, so pre-bias them by 3 (result wraps mod 16).
    function automatic logic [3:0] add3_fix(input logic [3:0] d);
        return (d >= ADD3_THRESH) ? (d + 4'd3) : d;
    endfunction

endpackage

// File: rtl/bcd_dabble_seq_sume3_unit.sv
// Single combinational add-3-if-greater-or-equal-5 cell, shared across
// all digits of the sequential converter.
import bcd_pkg::*;

module sume3_unit (
    input  logic [DIGIT_W-1:0] d,
    output logic [DIGIT_W-1:0] q
);

    // Pure combinational correction of one BCD digit.
    always_comb begin
        q = add3_fix(d);
    end

endmodule

// File: rtl/bcd_dabble_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3) using one shared
// add-3 cell; one digit corrected per clock, then one shift per input bit.
// Optional feature: define ASCII_OUT_EN to add the registered ascii_out port
// (one '0'-based ASCII character per digit).
import bcd_pkg::*;

module bcd_dabble_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [BIN_W-1:0]          bin_in,
    output logic                      busy,
    output logic                      done,
    output logic [DIGIT_W*DIGITS-1:0] bcd_out,
    output logic                      ovf
`ifdef ASCII_OUT_EN
    ,
    output logic [8*DIGITS-1:0]       ascii_out
`endif
);

    localparam int BCD_W = DIGIT_W * DIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    state_t             state_r;
    logic [BCD_W-1:0]   bcd_r;
    logic [BIN_W-1:0]   bin_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [IDX_W-1:0]   idx_r;
    logic               ovf_acc_r;

    logic [DIGIT_W-1:0] cur_digit_s;
    logic [DIGIT_W-1:0] fixed_digit_s;
    logic [BCD_W-1:0]   bcd_corr_s;
    logic [BCD_W-1:0]   bcd_final_s;

    // Select the digit addressed by the index for the shared correction cell.
    always_comb begin
        cur_digit_s = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_r == IDX_W'(k)) begin
                cur_digit_s = bcd_r[k*DIGIT_W +: DIGIT_W];
            end else begin
                cur_digit_s = cur_digit_s;
            end
        end
    end

    sume3_unit u_sume3 (
        .d (cur_digit_s),
        .q (fixed_digit_s)
    );

    // Write the corrected digit back into its slot; other digits pass through.
    always_comb begin
        bcd_corr_s = bcd_r;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_r == IDX_W'(k)) begin
                bcd_corr_s[k*DIGIT_W +: DIGIT_W] = fixed_digit_s;
            end else begin
                bcd_corr_s[k*DIGIT_W +: DIGIT_W] = bcd_r[k*DIGIT_W +: DIGIT_W];
            end
        end
    end

    // BCD field as it will look after the final shift (top bit drops out).
    always_comb begin
        bcd_final_s = {bcd_r[BCD_W-2:0], bin_r[BIN_W-1]};
    end

`ifdef ASCII_OUT_EN
    logic [8*DIGITS-1:0] ascii_next_s;

    // ASCII character per digit of the result about to be published.
    always_comb begin
        ascii_next_s = '0;
        for (int k = 0; k < DIGITS; k++) begin
            ascii_next_s[8*k +: 8] = ASCII_ZERO + {4'd0, bcd_final_s[k*DIGIT_W +: DIGIT_W]};
        end
    end
`endif

    // Conversion FSM: capture, per-digit correction, shift, publish result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            bcd_r     <= '0;
            bin_r     <= '0;
            cnt_r     <= '0;
            idx_r     <= '0;
            ovf_acc_r <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            bcd_out   <= '0;
            ovf       <= 1'b0;
`ifdef ASCII_OUT_EN
            ascii_out <= {DIGITS{ASCII_ZERO}};
`endif
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        bin_r     <= bin_in;
                        bcd_r     <= '0;
                        cnt_r     <= '0;
                        idx_r     <= '0;
                        ovf_acc_r <= 1'b0;
                        busy      <= 1'b1;
                        state_r   <= CORR;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                CORR: begin
                    bcd_r <= bcd_corr_s;
                    if (idx_r == IDX_LAST) begin
                        state_r <= SHIFT;
                    end else begin
                        idx_r   <= idx_r + IDX_W'(1);
                        state_r <= CORR;
                    end
                end
                SHIFT: begin
                    {bcd_r, bin_r} <= {bcd_r[BCD_W-2:0], bin_r, 1'b0};
                    ovf_acc_r      <= ovf_acc_r | bcd_r[BCD_W-1];
                    if (cnt_r == CNT_LAST) begin
                        bcd_out <= bcd_final_s;
                        ovf     <= ovf_acc_r | bcd_r[BCD_W-1];
`ifdef ASCII_OUT_EN
                        ascii_out <= ascii_next_s;
`endif
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        cnt_r   <= cnt_r + CNT_W'(1);
                        idx_r   <= '0;
                        state_r <= CORR;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
